// File: rtl/dram_result_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module   : dram_result_uart_dumper
// Purpose  : Snapshots NUM_CH DRAM read results and streams them as a framed
//            byte sequence (header, payload+separator per channel, optional
//            XOR checksum) through a uart_send-style busy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dram_result_uart_dumper #(
    parameter int         NUM_CH   = 16,
    parameter int         DATA_W   = 8,
    parameter logic [7:0] SEP_BYTE = 8'h0A,
    parameter logic [7:0] HDR_BYTE = 8'hA5,
    parameter int         CHK_EN   = 1,
    parameter int         ACK_TO   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     hex_mode,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     uart_busy,
    output logic                     uart_en,
    output logic [7:0]               uart_din,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int c_NB = (DATA_W + 7) / 8;
    localparam int c_NH = (DATA_W + 3) / 4;
    localparam int c_XW = c_NB * 8;
    localparam int c_CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_BW = $clog2(c_NH + 1);
    localparam int c_TW = $clog2(ACK_TO + 1);

    localparam logic [c_CW-1:0] c_LAST_CH = c_CW'(NUM_CH - 1);
    localparam logic [c_BW-1:0] c_LAST_NB = c_BW'(c_NB - 1);
    localparam logic [c_BW-1:0] c_LAST_NH = c_BW'(c_NH - 1);
    localparam logic [c_TW-1:0] c_LAST_TO = c_TW'(ACK_TO - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_EMIT    = 2'd1;
    localparam logic [1:0] c_WAIT_HI = 2'd2;
    localparam logic [1:0] c_WAIT_LO = 2'd3;

    localparam logic [1:0] c_PH_HDR = 2'd0;
    localparam logic [1:0] c_PH_PAY = 2'd1;
    localparam logic [1:0] c_PH_SEP = 2'd2;
    localparam logic [1:0] c_PH_CHK = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               w_next;
    logic [1:0]               r_phase;
    logic [c_CW-1:0]          r_ch;
    logic [c_BW-1:0]          r_bi;
    logic [c_TW-1:0]          r_to;
    logic [NUM_CH*DATA_W-1:0] r_snap;
    logic                     r_hex;
    logic [7:0]               r_chk;
    logic [7:0]               r_hold;
    logic                     r_done;
    logic                     r_ovr;

    logic [DATA_W-1:0]        w_val;
    logic [c_XW-1:0]          w_ext;
    logic [7:0]               w_bin;
    logic [3:0]               w_nib;
    logic [7:0]               w_asc;
    logic [7:0]               w_byte;
    logic                     w_last;
    logic                     w_pay_end;
    logic                     w_adv;

    // Current frame byte, derived from the phase/channel/byte-index pointer.
    always_comb begin
        w_val = r_snap[r_ch*DATA_W +: DATA_W];
        w_ext = '0;
        w_ext[DATA_W-1:0] = w_val;
        w_bin = 8'h00;
        for (int i = 0; i < c_NB; i++) begin
            if (r_bi == c_BW'(i)) w_bin = w_ext[(c_NB-1-i)*8 +: 8];
        end
        w_nib = 4'h0;
        for (int i = 0; i < c_NH; i++) begin
            if (r_bi == c_BW'(i)) w_nib = w_ext[(c_NH-1-i)*4 +: 4];
        end
        w_asc = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
        case (r_phase)
            c_PH_HDR: w_byte = HDR_BYTE;
            c_PH_PAY: w_byte = r_hex ? w_asc : w_bin;
            c_PH_SEP: w_byte = SEP_BYTE;
            default:  w_byte = r_chk;
        endcase
    end

    assign w_last    = (r_phase == c_PH_CHK) ||
                       ((r_phase == c_PH_SEP) && (r_ch == c_LAST_CH) && (CHK_EN == 0));
    assign w_pay_end = (r_bi == (r_hex ? c_LAST_NH : c_LAST_NB));
    // An unanswered strobe counts as consumed once the ack window closes.
    assign w_adv     = ((r_state == c_WAIT_HI) && !uart_busy && (r_to == c_LAST_TO)) ||
                       ((r_state == c_WAIT_LO) && !uart_busy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:    if (start) w_next = c_EMIT;
            c_EMIT:    w_next = c_WAIT_HI;
            c_WAIT_HI: begin
                if (uart_busy)  w_next = c_WAIT_LO;
                else if (w_adv) w_next = w_last ? c_IDLE : c_EMIT;
            end
            c_WAIT_LO: if (w_adv) w_next = w_last ? c_IDLE : c_EMIT;
            default:   w_next = c_IDLE;
        endcase
    end

    always_comb begin
        uart_en  = 1'b0;
        uart_din = r_hold;
        busy     = (r_state != c_IDLE);
        done     = r_done;
        overrun  = r_ovr;
        if (r_state == c_EMIT) begin
            uart_en  = 1'b1;
            uart_din = w_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= c_PH_HDR;
            r_ch    <= '0;
            r_bi    <= '0;
            r_to    <= '0;
            r_snap  <= '0;
            r_hex   <= 1'b0;
            r_chk   <= 8'h00;
            r_hold  <= 8'h00;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && (r_state != c_IDLE)) r_ovr <= 1'b1;
            if (start && (r_state == c_IDLE)) begin
                r_snap  <= ch_data;
                r_hex   <= hex_mode;
                r_ovr   <= 1'b0;
                r_chk   <= 8'h00;
                r_phase <= c_PH_HDR;
                r_ch    <= '0;
                r_bi    <= '0;
            end
            if (r_state == c_EMIT) begin
                r_chk  <= r_chk ^ w_byte;
                r_hold <= w_byte;
                r_to   <= '0;
            end
            if ((r_state == c_WAIT_HI) && !uart_busy) r_to <= r_to + 1'b1;
            if (w_adv) begin
                if (w_last) begin
                    r_done <= 1'b1;
                end else begin
                    case (r_phase)
                        c_PH_HDR: begin
                            r_phase <= c_PH_PAY;
                            r_bi    <= '0;
                        end
                        c_PH_PAY: begin
                            if (w_pay_end) begin
                                r_phase <= c_PH_SEP;
                                r_bi    <= '0;
                            end else begin
                                r_bi <= r_bi + 1'b1;
                            end
                        end
                        c_PH_SEP: begin
                            if (r_ch == c_LAST_CH) begin
                                r_phase <= c_PH_CHK;
                            end else begin
                                r_ch    <= r_ch + 1'b1;
                                r_phase <= c_PH_PAY;
                            end
                        end
                        default: r_phase <= c_PH_CHK;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dram_result_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_result_uart_dumper
// Purpose  : Self-checking bench for dram_result_uart_dumper (default and
//            12-bit/2-channel configurations) against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_result_uart_dumper;

    localparam int c_NCH_A = 16;
    localparam int c_DW_A  = 8;
    localparam int c_NCH_B = 2;
    localparam int c_DW_B  = 12;
    localparam int c_ACK   = 4;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic                       start_a, hex_a, ubusy_a, en_a, busy_a, done_a, ovr_a;
    logic [7:0]                 din_a;
    logic [c_NCH_A*c_DW_A-1:0]  data_a;
    logic                       start_b, hex_b, ubusy_b, en_b, busy_b, done_b, ovr_b;
    logic [7:0]                 din_b;
    logic [c_NCH_B*c_DW_B-1:0]  data_b;

    dram_result_uart_dumper #(
        .NUM_CH(c_NCH_A), .DATA_W(c_DW_A), .SEP_BYTE(8'h0A), .HDR_BYTE(8'hA5),
        .CHK_EN(1), .ACK_TO(c_ACK)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .hex_mode(hex_a), .ch_data(data_a),
        .uart_busy(ubusy_a), .uart_en(en_a), .uart_din(din_a), .busy(busy_a),
        .done(done_a), .overrun(ovr_a)
    );

    dram_result_uart_dumper #(
        .NUM_CH(c_NCH_B), .DATA_W(c_DW_B), .SEP_BYTE(8'h0A), .HDR_BYTE(8'hA5),
        .CHK_EN(1), .ACK_TO(c_ACK)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .hex_mode(hex_b), .ch_data(data_b),
        .uart_busy(ubusy_b), .uart_en(en_b), .uart_din(din_b), .busy(busy_b),
        .done(done_b), .overrun(ovr_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bq_t  got_a, got_b, exp_q;
    int   en_cyc_a[$];
    int   done_cnt_a = 0, done_cyc_a = 0, fall_cyc_a = 0, proto_err_a = 0;
    int   en_cnt_b = 0;
    int   umode_a = 0;
    logic prev_en_a = 1'b0, prev_ub_a = 1'b0;

    // Frame model: header, per-channel MS-first payload + separator, XOR checksum.
    function automatic void fill_exp(input int nch, input int dw, input bit hex,
                                     input logic [127:0] flat);
        logic [127:0] mask;
        logic [31:0]  v;
        logic [7:0]   b, chk;
        int           nb, nh, n;
        mask = (128'h1 << dw) - 128'h1;
        nb = (dw + 7) / 8;
        nh = (dw + 3) / 4;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        chk = 8'hA5;
        for (int ch = 0; ch < nch; ch++) begin
            v = 32'((flat >> (ch * dw)) & mask);
            if (hex) begin
                for (int i = nh - 1; i >= 0; i--) begin
                    n = int'((v >> (4 * i)) & 32'hF);
                    b = (n < 10) ? 8'(48 + n) : 8'(55 + n);
                    exp_q.push_back(b);
                    chk = chk ^ b;
                end
            end else begin
                for (int i = nb - 1; i >= 0; i--) begin
                    b = 8'((v >> (8 * i)) & 32'hFF);
                    exp_q.push_back(b);
                    chk = chk ^ b;
                end
            end
            exp_q.push_back(8'h0A);
            chk = chk ^ 8'h0A;
        end
        exp_q.push_back(chk);
    endfunction

    function automatic int first_diff(input bq_t g, input bq_t e);
        if (g.size() != e.size()) return (g.size() < e.size()) ? g.size() : e.size();
        for (int i = 0; i < g.size(); i++) if (g[i] !== e[i]) return i;
        return -1;
    endfunction

    // Byte/strobe monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (en_a === 1'b1) begin
                got_a.push_back(din_a);
                en_cyc_a.push_back(cyc);
                if (prev_en_a || ubusy_a) proto_err_a++;
            end
            if (prev_ub_a && !ubusy_a) fall_cyc_a = cyc;
            if (done_a === 1'b1) begin
                done_cnt_a++;
                done_cyc_a = cyc;
            end
            prev_en_a = en_a;
            prev_ub_a = ubusy_a;
            if (en_b === 1'b1) begin
                got_b.push_back(din_b);
                en_cnt_b++;
            end
        end
    end

    // uart_send behavioural models: random ack latency and busy length.
    initial begin
        ubusy_a = 1'b0;
        forever begin
            @(negedge clk);
            if (en_a === 1'b1 && umode_a == 0) begin
                int lat, hold;
                lat  = $urandom_range(0, 2);
                hold = $urandom_range(1, 4);
                repeat (lat + 1) @(posedge clk);
                #1 ubusy_a = 1'b1;
                repeat (hold) @(posedge clk);
                #1 ubusy_a = 1'b0;
            end
        end
    end

    initial begin
        ubusy_b = 1'b0;
        forever begin
            @(negedge clk);
            if (en_b === 1'b1) begin
                int lat, hold;
                lat  = $urandom_range(0, 2);
                hold = $urandom_range(1, 3);
                repeat (lat + 1) @(posedge clk);
                #1 ubusy_b = 1'b1;
                repeat (hold) @(posedge clk);
                #1 ubusy_b = 1'b0;
            end
        end
    end

    task automatic pulse_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic pulse_b();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
    endtask

    task automatic wait_done_a(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic wait_done_b(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done_b === 1'b1) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b0; hex_a = 1'b0; data_a = '0;
        start_b = 1'b0; hex_b = 1'b0; data_b = '0;
        repeat (3) @(negedge clk);
        n_checks += 10;
        if (en_a !== 1'b0)    begin n_fail++; $display("FAIL rst_en_a: got %b want 0", en_a); end
        if (din_a !== 8'h00)  begin n_fail++; $display("FAIL rst_din_a: got %h want 00", din_a); end
        if (busy_a !== 1'b0)  begin n_fail++; $display("FAIL rst_busy_a: got %b want 0", busy_a); end
        if (done_a !== 1'b0)  begin n_fail++; $display("FAIL rst_done_a: got %b want 0", done_a); end
        if (ovr_a !== 1'b0)   begin n_fail++; $display("FAIL rst_ovr_a: got %b want 0", ovr_a); end
        if (en_b !== 1'b0)    begin n_fail++; $display("FAIL rst_en_b: got %b want 0", en_b); end
        if (din_b !== 8'h00)  begin n_fail++; $display("FAIL rst_din_b: got %h want 00", din_b); end
        if (busy_b !== 1'b0)  begin n_fail++; $display("FAIL rst_busy_b: got %b want 0", busy_b); end
        if (done_b !== 1'b0)  begin n_fail++; $display("FAIL rst_done_b: got %b want 0", done_b); end
        if (ovr_b !== 1'b0)   begin n_fail++; $display("FAIL rst_ovr_b: got %b want 0", ovr_b); end
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_binary_const();
        bit ok; int d, d0;
        data_a = {c_NCH_A{8'h55}};
        hex_a  = 1'b0;
        fill_exp(c_NCH_A, c_DW_A, 1'b0, 128'(data_a));
        got_a.delete(); d0 = done_cnt_a; proto_err_a = 0;
        pulse_a();
        n_checks++;
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL bin55_busy_start: got %b want 1", busy_a); end
        wait_done_a(3000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bin55_timeout: done %b want 1", ok); end
        n_checks++;
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL bin55_busy_at_done: got %b want 0", busy_a); end
        n_checks++;
        if (done_cyc_a - fall_cyc_a != 1) begin n_fail++; $display("FAIL bin55_done_latency: got %0d want 1", done_cyc_a - fall_cyc_a); end
        n_checks++;
        if (got_a.size() != 34) begin n_fail++; $display("FAIL bin55_len: got %0d want 34", got_a.size()); end
        d = first_diff(got_a, exp_q);
        n_checks++;
        if (d != -1) begin n_fail++; $display("FAIL bin55_content: first bad index %0d got %0d bytes want %0d", d, got_a.size(), exp_q.size()); end
        repeat (10) @(negedge clk);
        n_checks += 2;
        if (done_cnt_a - d0 != 1) begin n_fail++; $display("FAIL bin55_done_count: got %0d want 1", done_cnt_a - d0); end
        if (proto_err_a != 0) begin n_fail++; $display("FAIL bin55_strobe_protocol: got %0d errors want 0", proto_err_a); end
    endtask

    task automatic test_one_channel(input bit hex, input int want_len, input logic [7:0] want_chk);
        bit ok; int d;
        data_a = '0;
        data_a[7:0] = 8'h3C;
        hex_a = hex;
        fill_exp(c_NCH_A, c_DW_A, hex, 128'(data_a));
        got_a.delete();
        pulse_a();
        wait_done_a(3000, ok);
        n_checks += 4;
        if (!ok) begin n_fail++; $display("FAIL ch0_3c_timeout hex=%0d: done %b want 1", hex, ok); end
        if (got_a.size() != want_len) begin n_fail++; $display("FAIL ch0_3c_len hex=%0d: got %0d want %0d", hex, got_a.size(), want_len); end
        if (got_a.size() == 0 || got_a[got_a.size()-1] !== want_chk) begin
            n_fail++; $display("FAIL ch0_3c_chk hex=%0d: got %h want %h", hex, (got_a.size() != 0) ? got_a[got_a.size()-1] : 8'hxx, want_chk);
        end
        d = first_diff(got_a, exp_q);
        if (d != -1) begin n_fail++; $display("FAIL ch0_3c_content hex=%0d: first bad index %0d", hex, d); end
    endtask

    task automatic test_random_frames();
        bit ok; int d;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 4; k++) data_a[k*32 +: 32] = $urandom;
            hex_a = 1'($urandom_range(0, 1));
            fill_exp(c_NCH_A, c_DW_A, hex_a, 128'(data_a));
            got_a.delete();
            pulse_a();
            wait_done_a(3000, ok);
            d = first_diff(got_a, exp_q);
            n_checks += 2;
            if (!ok) begin n_fail++; $display("FAIL rand_timeout frame %0d: done %b want 1", f, ok); end
            if (d != -1) begin n_fail++; $display("FAIL rand_content frame %0d: first bad index %0d got %0d want %0d bytes", f, d, got_a.size(), exp_q.size()); end
        end
    endtask

    task automatic test_overrun();
        bit ok; int d, n;
        for (int k = 0; k < 4; k++) data_a[k*32 +: 32] = $urandom;
        hex_a = 1'b1;
        fill_exp(c_NCH_A, c_DW_A, 1'b1, 128'(data_a));
        got_a.delete();
        pulse_a();
        for (int i = 0; i < 500 && got_a.size() < 5; i++) @(negedge clk);
        data_a = {c_NCH_A{8'hFF}};
        pulse_a();
        n_checks++;
        if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", ovr_a); end
        wait_done_a(3000, ok);
        d = first_diff(got_a, exp_q);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL ovr_timeout: done %b want 1", ok); end
        if (d != -1) begin n_fail++; $display("FAIL ovr_snapshot_content: first bad index %0d", d); end
        if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", ovr_a); end
        n = got_a.size();
        repeat (40) @(negedge clk);
        n_checks += 2;
        if (got_a.size() != n) begin n_fail++; $display("FAIL ovr_extra_frame: got %0d bytes want %0d", got_a.size(), n); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ovr_idle_busy: got %b want 0", busy_a); end
        fill_exp(c_NCH_A, c_DW_A, 1'b1, 128'(data_a));
        got_a.delete();
        pulse_a();
        n_checks++;
        if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", ovr_a); end
        wait_done_a(3000, ok);
        d = first_diff(got_a, exp_q);
        n_checks++;
        if (!ok || d != -1) begin n_fail++; $display("FAIL ovr_next_frame: done %b first bad index %0d", ok, d); end
    endtask

    task automatic test_back_to_back();
        bit ok; int d;
        for (int k = 0; k < 4; k++) data_a[k*32 +: 32] = $urandom;
        hex_a = 1'b0;
        fill_exp(c_NCH_A, c_DW_A, 1'b0, 128'(data_a));
        got_a.delete();
        pulse_a();
        wait_done_a(3000, ok);
        d = first_diff(got_a, exp_q);
        n_checks++;
        if (!ok || d != -1) begin n_fail++; $display("FAIL b2b_first: done %b first bad index %0d", ok, d); end
        for (int k = 0; k < 4; k++) data_a[k*32 +: 32] = $urandom;
        hex_a = 1'b1;
        fill_exp(c_NCH_A, c_DW_A, 1'b1, 128'(data_a));
        got_a.delete();
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n_checks += 2;
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy got %b want 1", busy_a); end
        if (ovr_a !== 1'b0)  begin n_fail++; $display("FAIL b2b_no_overrun: got %b want 0", ovr_a); end
        wait_done_a(3000, ok);
        d = first_diff(got_a, exp_q);
        n_checks++;
        if (!ok || d != -1) begin n_fail++; $display("FAIL b2b_second: done %b first bad index %0d", ok, d); end
    endtask

    task automatic test_busy_tied_low();
        bit ok; int d, d0, bad;
        umode_a = 1;
        for (int k = 0; k < 4; k++) data_a[k*32 +: 32] = $urandom;
        hex_a = 1'b0;
        fill_exp(c_NCH_A, c_DW_A, 1'b0, 128'(data_a));
        got_a.delete(); en_cyc_a.delete(); d0 = done_cnt_a;
        pulse_a();
        wait_done_a(3000, ok);
        d = first_diff(got_a, exp_q);
        bad = 0;
        for (int i = 1; i < en_cyc_a.size(); i++) if (en_cyc_a[i] - en_cyc_a[i-1] != c_ACK + 1) bad++;
        repeat (20) @(negedge clk);
        n_checks += 5;
        if (!ok) begin n_fail++; $display("FAIL tied_timeout: done %b want 1", ok); end
        if (got_a.size() != 34) begin n_fail++; $display("FAIL tied_len: got %0d want 34", got_a.size()); end
        if (d != -1) begin n_fail++; $display("FAIL tied_content: first bad index %0d", d); end
        if (bad != 0) begin n_fail++; $display("FAIL tied_stride: got %0d gaps not equal to %0d", bad, c_ACK + 1); end
        if (done_cnt_a - d0 != 1) begin n_fail++; $display("FAIL tied_done_count: got %0d want 1", done_cnt_a - d0); end
        umode_a = 0;
    endtask

    task automatic test_dw12();
        bit ok; int d;
        data_b = {12'h001, 12'hABC};
        hex_b  = 1'b1;
        fill_exp(c_NCH_B, c_DW_B, 1'b1, 128'(data_b));
        got_b.delete();
        pulse_b();
        wait_done_b(2000, ok);
        d = first_diff(got_b, exp_q);
        n_checks += 4;
        if (!ok) begin n_fail++; $display("FAIL dw12_timeout: done %b want 1", ok); end
        if (got_b.size() != 10) begin n_fail++; $display("FAIL dw12_len: got %0d want 10", got_b.size()); end
        if (got_b.size() == 0 || got_b[got_b.size()-1] !== 8'hD4) begin
            n_fail++; $display("FAIL dw12_chk: got %h want d4", (got_b.size() != 0) ? got_b[got_b.size()-1] : 8'hxx);
        end
        if (d != -1) begin n_fail++; $display("FAIL dw12_content: first bad index %0d", d); end
        data_b = 24'($urandom);
        hex_b  = 1'b0;
        fill_exp(c_NCH_B, c_DW_B, 1'b0, 128'(data_b));
        got_b.delete();
        pulse_b();
        wait_done_b(2000, ok);
        d = first_diff(got_b, exp_q);
        n_checks += 2;
        if (got_b.size() != 8) begin n_fail++; $display("FAIL dw12_bin_len: got %0d want 8", got_b.size()); end
        if (!ok || d != -1) begin n_fail++; $display("FAIL dw12_bin_content: done %b first bad index %0d", ok, d); end
    endtask

    task automatic test_reset_midframe();
        int n;
        bit seen;
        data_b = 24'($urandom);
        hex_b  = 1'b1;
        pulse_b();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (en_b === 1'b1 && got_b.size() >= 3) begin seen = 1'b1; break; end
        end
        #1 rst = 1'b1;
        #1;
        n_checks += 3;
        if (!seen) begin n_fail++; $display("FAIL midrst_strobe_seen: got %b want 1", seen); end
        if (en_b !== 1'b0)   begin n_fail++; $display("FAIL midrst_en: got %b want 0", en_b); end
        if (busy_b !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy_b); end
        n = en_cnt_b;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        n_checks += 3;
        if (en_cnt_b != n) begin n_fail++; $display("FAIL midrst_no_more_strobes: got %0d extra want 0", en_cnt_b - n); end
        if (din_b !== 8'h00) begin n_fail++; $display("FAIL midrst_din: got %h want 00", din_b); end
        if (done_b !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done_b); end
    endtask

    initial begin
        test_reset();
        test_binary_const();
        test_one_channel(1'b0, 34, 8'h99);
        test_one_channel(1'b1, 50, 8'hD5);
        test_random_frames();
        test_overrun();
        test_back_to_back();
        test_busy_tied_low();
        test_dw12();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
